// File: rtl/midi_pkg.sv
// +----------------------------------------------------------------------------+
// | midi_pkg : shared MIDI constants, widths and types for note tracking/render |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package midi_pkg;

  localparam int DEFAULT_NUM_VOICES = 5;
  localparam int DEFAULT_NOTE_WIDTH = 8;
  localparam int DEFAULT_DUR_WIDTH  = 30;

  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  typedef enum logic [1:0] {
    MSG_NONE = 2'd0,
    MSG_ON   = 2'd1,
    MSG_OFF  = 2'd2
  } msg_kind_e;

  typedef struct packed {
    logic                          active;
    logic [DEFAULT_NOTE_WIDTH-1:0] note;
    logic [DEFAULT_DUR_WIDTH-1:0]  count;
  } voice_slot_t;

  typedef struct packed {
    logic [DEFAULT_NOTE_WIDTH-1:0] note;
    logic [DEFAULT_DUR_WIDTH-1:0]  duration;
  } history_entry_t;

  // A note-on carrying zero velocity is the running-status form of note-off.
  function automatic msg_kind_e classify_msg(
    input logic       valid,
    input logic [3:0] status,
    input logic [6:0] velocity
  );
    if (valid) begin
      if (status == MIDI_NOTE_ON && velocity != 7'd0) return MSG_ON;
      if (status == MIDI_NOTE_OFF || status == MIDI_NOTE_ON) return MSG_OFF;
    end
    return MSG_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_duration_tracker_voice_slot.sv
// +----------------------------------------------------------------------------+
// | voice_slot : one held-note slot with a saturating cycle counter            |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module voice_slot
  import midi_pkg::*;
#(
  parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int DUR_WIDTH  = DEFAULT_DUR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic                  release_i,
  input  logic                  retrigger_i,
  input  logic [NOTE_WIDTH-1:0] note_i,
  output logic                  match_o,
  output logic                  active_o,
  output logic [NOTE_WIDTH-1:0] note_o,
  output logic [DUR_WIDTH-1:0]  count_o
);

  localparam logic [DUR_WIDTH-1:0] c_dur_one = DUR_WIDTH'(1);

  logic                  active_q, active_d;
  logic [NOTE_WIDTH-1:0] note_q, note_d;
  logic [DUR_WIDTH-1:0]  count_q, count_d;

  always_comb begin
    active_d = active_q;
    note_d   = note_q;
    count_d  = count_q;
    if (release_i) begin
      active_d = 1'b0;
      count_d  = '0;
    end else if (alloc_i) begin
      active_d = 1'b1;
      note_d   = note_i;
      count_d  = '0;
    end else if (retrigger_i) begin
      count_d  = '0;
    end else if (active_q && (count_q != '1)) begin
      count_d  = count_q + c_dur_one;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      note_q   <= '0;
      count_q  <= '0;
    end else begin
      active_q <= active_d;
      note_q   <= note_d;
      count_q  <= count_d;
    end
  end

  assign match_o  = active_q && (note_q == note_i);
  assign active_o = active_q;
  assign note_o   = note_q;
  assign count_o  = count_q;

endmodule

`default_nettype wire

// File: rtl/note_duration_tracker.sv
// +----------------------------------------------------------------------------+
// | note_duration_tracker : times held MIDI notes, keeps last completed notes |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module note_duration_tracker
  import midi_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int NOTE_WIDTH = DEFAULT_NOTE_WIDTH,
  parameter int DUR_WIDTH  = DEFAULT_DUR_WIDTH
) (
  input  logic                                  clk_camera_in,
  input  logic                                  rst_in,
  input  logic                                  midi_valid_in,
  input  logic [3:0]                            midi_status_in,
  input  logic [NOTE_WIDTH-1:0]                 midi_note_in,
  input  logic [6:0]                            midi_velocity_in,
  output logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] notes_out,
  output logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]  durations_out,
  output logic [NUM_VOICES-1:0]                 active_mask_out,
  output logic                                  notes_valid_out,
  output logic                                  overflow_out
);

  localparam logic [DUR_WIDTH-1:0] c_dur_one = DUR_WIDTH'(1);

  msg_kind_e                            w_kind;
  logic                                 w_is_on, w_is_off;
  logic [NUM_VOICES-1:0]                w_match, w_active, w_free_onehot;
  logic [NUM_VOICES-1:0]                w_alloc, w_release, w_retrig;
  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] w_slot_note;
  logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]  w_slot_count;
  logic                                 w_any_match, w_any_free;
  logic                                 w_push, w_overflow;
  logic [NOTE_WIDTH-1:0]                w_sel_note;
  logic [DUR_WIDTH-1:0]                 w_sel_count, w_sel_dur;

  logic [NUM_VOICES-1:0][NOTE_WIDTH-1:0] hist_note_q, hist_note_d;
  logic [NUM_VOICES-1:0][DUR_WIDTH-1:0]  hist_dur_q, hist_dur_d;
  logic                                 valid_q, overflow_q;

  assign w_kind   = classify_msg(midi_valid_in, midi_status_in, midi_velocity_in);
  assign w_is_on  = (w_kind == MSG_ON);
  assign w_is_off = (w_kind == MSG_OFF);

  always_comb begin
    w_free_onehot = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!w_active[i]) begin
        w_free_onehot    = '0;
        w_free_onehot[i] = 1'b1;
      end
    end
  end

  assign w_any_match = |w_match;
  assign w_any_free  = |w_free_onehot;

  assign w_retrig   = w_is_on ? w_match : '0;
  assign w_alloc    = (w_is_on && !w_any_match) ? w_free_onehot : '0;
  assign w_release  = w_is_off ? w_match : '0;
  assign w_overflow = w_is_on && !w_any_match && !w_any_free;
  assign w_push     = w_is_off && w_any_match;

  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_slot #(
        .NOTE_WIDTH (NOTE_WIDTH),
        .DUR_WIDTH  (DUR_WIDTH)
      ) u_slot (
        .clk_i       (clk_camera_in),
        .rst_i       (rst_in),
        .alloc_i     (w_alloc[g]),
        .release_i   (w_release[g]),
        .retrigger_i (w_retrig[g]),
        .note_i      (midi_note_in),
        .match_o     (w_match[g]),
        .active_o    (w_active[g]),
        .note_o      (w_slot_note[g]),
        .count_o     (w_slot_count[g])
      );
    end
  endgenerate

  // Match is one-hot (no duplicate held notes), so an OR-mux suffices.
  always_comb begin
    w_sel_note  = '0;
    w_sel_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_sel_note  = w_sel_note  | (w_slot_note[i]  & {NOTE_WIDTH{w_match[i]}});
      w_sel_count = w_sel_count | (w_slot_count[i] & {DUR_WIDTH{w_match[i]}});
    end
  end

  // The counter lags the release edge by one, so the edge itself is added here.
  assign w_sel_dur = (w_sel_count == '1) ? w_sel_count : (w_sel_count + c_dur_one);

  always_comb begin
    hist_note_d = hist_note_q;
    hist_dur_d  = hist_dur_q;
    if (w_push) begin
      for (int i = NUM_VOICES - 1; i >= 1; i--) begin
        hist_note_d[i] = hist_note_q[i-1];
        hist_dur_d[i]  = hist_dur_q[i-1];
      end
      hist_note_d[0] = w_sel_note;
      hist_dur_d[0]  = w_sel_dur;
    end
  end

  always_ff @(posedge clk_camera_in) begin
    if (rst_in) begin
      hist_note_q <= '0;
      hist_dur_q  <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      hist_note_q <= hist_note_d;
      hist_dur_q  <= hist_dur_d;
      valid_q     <= w_push;
      overflow_q  <= w_overflow;
    end
  end

  assign notes_out       = hist_note_q;
  assign durations_out   = hist_dur_q;
  assign active_mask_out = w_active;
  assign notes_valid_out = valid_q;
  assign overflow_out    = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_note_duration_tracker.sv
// +----------------------------------------------------------------------------+
// | tb_note_duration_tracker : directed scoreboard bench for the note tracker |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_note_duration_tracker;

  localparam int NV = 5;
  localparam int NW = 8;
  localparam int DW = 30;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_in = 1'b0;
  logic          midi_valid_in = 1'b0;
  logic [3:0]    midi_status_in = '0;
  logic [NW-1:0] midi_note_in = '0;
  logic [6:0]    midi_velocity_in = '0;

  logic [NV-1:0][NW-1:0] notes_out;
  logic [NV-1:0][DW-1:0] durations_out;
  logic [NV-1:0]         active_mask_out;
  logic                  notes_valid_out, overflow_out;

  logic          s_vld = 1'b0;
  logic [3:0]    s_st = '0;
  logic [NW-1:0] s_nt = '0;
  logic [6:0]    s_vel = '0;
  logic [NV-1:0][NW-1:0] s_notes;
  logic [NV-1:0][SW-1:0] s_durs;
  logic [NV-1:0]         s_mask;
  logic                  s_nv, s_ovf;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  note_duration_tracker #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .DUR_WIDTH(DW)) dut (
    .clk_camera_in    (clk),
    .rst_in           (rst_in),
    .midi_valid_in    (midi_valid_in),
    .midi_status_in   (midi_status_in),
    .midi_note_in     (midi_note_in),
    .midi_velocity_in (midi_velocity_in),
    .notes_out        (notes_out),
    .durations_out    (durations_out),
    .active_mask_out  (active_mask_out),
    .notes_valid_out  (notes_valid_out),
    .overflow_out     (overflow_out)
  );

  // Narrow-counter instance makes saturation reachable in a few cycles.
  note_duration_tracker #(.NUM_VOICES(NV), .NOTE_WIDTH(NW), .DUR_WIDTH(SW)) dut_s (
    .clk_camera_in    (clk),
    .rst_in           (rst_in),
    .midi_valid_in    (s_vld),
    .midi_status_in   (s_st),
    .midi_note_in     (s_nt),
    .midi_velocity_in (s_vel),
    .notes_out        (s_notes),
    .durations_out    (s_durs),
    .active_mask_out  (s_mask),
    .notes_valid_out  (s_nv),
    .overflow_out     (s_ovf)
  );

  typedef struct {
    logic [NW-1:0] note;
    longint        dur;
  } exp_t;

  exp_t          exp_q[$];
  bit            m_act[NV];
  logic [NW-1:0] m_note[NV];
  int            m_on[NV];
  logic [NW-1:0] h_note[NV];
  longint        h_dur[NV];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input bit v, input logic [3:0] s, input logic [NW-1:0] n,
                      input logic [6:0] ve, input bit r);
    int            m;
    int            f;
    bit            exp_ovf;
    logic [NV-1:0] exp_mask;
    exp_t          e;
    @(negedge clk);
    rst_in = r; midi_valid_in = v; midi_status_in = s; midi_note_in = n; midi_velocity_in = ve;
    @(posedge clk);
    #1;
    rst_in = 1'b0;
    midi_valid_in = 1'b0;
    exp_ovf = 1'b0;
    if (r) begin
      for (int i = 0; i < NV; i++) begin
        m_act[i] = 1'b0; h_note[i] = '0; h_dur[i] = 0;
      end
      exp_q.delete();
    end else if (v && (s == 4'h9 || s == 4'h8)) begin
      m = -1; f = -1;
      for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == n) m = i;
      for (int i = NV - 1; i >= 0; i--) if (!m_act[i]) f = i;
      if (s == 4'h9 && ve != 7'd0) begin
        if (m >= 0) m_on[m] = cyc;
        else if (f >= 0) begin m_act[f] = 1'b1; m_note[f] = n; m_on[f] = cyc; end
        else exp_ovf = 1'b1;
      end else if (m >= 0) begin
        for (int i = NV - 1; i > 0; i--) begin h_note[i] = h_note[i-1]; h_dur[i] = h_dur[i-1]; end
        h_note[0] = n;
        h_dur[0]  = longint'(cyc - m_on[m]);
        m_act[m]  = 1'b0;
        e.note = n; e.dur = h_dur[0];
        exp_q.push_back(e);
      end
    end
    chk("notes_valid", 64'(notes_valid_out), 64'(exp_q.size() > 0));
    if (notes_valid_out === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_note", 64'(notes_out[0]), 64'(e.note));
      chk("sb_dur", 64'(durations_out[0]), 64'(e.dur));
    end
    exp_q.delete();
    for (int i = 0; i < NV; i++) exp_mask[i] = m_act[i];
    chk("overflow", 64'(overflow_out), 64'(exp_ovf));
    chk("active_mask", 64'(active_mask_out), 64'(exp_mask));
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("hist_note[%0d]", i), 64'(notes_out[i]), 64'(h_note[i]));
      chk($sformatf("hist_dur[%0d]", i), 64'(durations_out[i]), 64'(h_dur[i]));
    end
  endtask

  task automatic on(input logic [NW-1:0] n);
    step(1'b1, 4'h9, n, 7'd100, 1'b0);
  endtask

  task automatic off(input logic [NW-1:0] n);
    step(1'b1, 4'h8, n, 7'd0, 1'b0);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 4'h0, '0, 7'd0, 1'b0);
  endtask

  initial begin
    step(1'b0, 4'h0, '0, 7'd0, 1'b1);
    chk("rst_s_mask", 64'(s_mask), 64'd0);
    chk("rst_s_durs", 64'(s_durs), 64'd0);

    // Single note: on at edge 10, off 15 edges later.
    idle(9);
    on(8'd60);
    idle(14);
    off(8'd60);
    chk("t1_note", 64'(notes_out[0]), 64'd60);
    chk("t1_dur", 64'(durations_out[0]), 64'd15);
    idle(1);

    // Fill every slot, then one more.
    for (int i = 0; i < 5; i++) on(8'(60 + i));
    chk("t2_full_mask", 64'(active_mask_out), 64'h1f);
    on(8'd65);
    idle(1);
    off(8'd65);

    off(8'd60);
    idle(2);
    off(8'd61);
    off(8'd62);
    chk("t3_n0", 64'(notes_out[0]), 64'd62);
    chk("t3_n1", 64'(notes_out[1]), 64'd61);
    chk("t3_n2", 64'(notes_out[2]), 64'd60);
    off(8'd63);
    off(8'd64);
    chk("t3_evict", 64'(notes_out[4]), 64'd60);
    chk("t3_mask", 64'(active_mask_out), 64'd0);

    // Retrigger restarts timing without a history entry.
    step(1'b0, 4'h0, '0, 7'd0, 1'b1);
    on(8'd64);
    idle(7);
    on(8'd64);
    idle(11);
    off(8'd64);
    chk("t4_note", 64'(notes_out[0]), 64'd64);
    chk("t4_dur", 64'(durations_out[0]), 64'd12);
    chk("t4_single", 64'(notes_out[1]), 64'd0);

    on(8'd67);
    idle(3);
    step(1'b1, 4'h9, 8'd67, 7'd0, 1'b0);
    chk("t5_vel0_release", 64'(notes_out[0]), 64'd67);
    off(8'd70);
    step(1'b1, 4'hB, 8'd68, 7'd100, 1'b0);
    chk("t5_statusB_mask", 64'(active_mask_out), 64'd0);

    // Reset wins over a same-cycle release.
    on(8'd1);
    on(8'd2);
    on(8'd3);
    step(1'b1, 4'h8, 8'd1, 7'd0, 1'b1);
    chk("t6_mask", 64'(active_mask_out), 64'd0);
    chk("t6_notes", 64'(notes_out), 64'd0);
    chk("t6_valid", 64'(notes_valid_out), 64'd0);

    // Saturation on the 4-bit counter instance.
    s_vld = 1'b1; s_st = 4'h9; s_nt = 8'd50; s_vel = 7'd90;
    idle(1);
    s_vld = 1'b0;
    idle(19);
    chk("s_held_mask", 64'(s_mask), 64'd1);
    chk("s_held_hist", 64'(s_notes[0]), 64'd0);
    s_vld = 1'b1; s_st = 4'h8; s_nt = 8'd50; s_vel = 7'd0;
    idle(1);
    s_vld = 1'b0;
    chk("s_sat_valid", 64'(s_nv), 64'd1);
    chk("s_sat_note", 64'(s_notes[0]), 64'd50);
    chk("s_sat_dur", 64'(s_durs[0]), 64'd15);
    chk("s_sat_mask", 64'(s_mask), 64'd0);
    idle(1);
    chk("s_pulse_len", 64'(s_nv), 64'd0);
    s_vld = 1'b1; s_st = 4'h9; s_nt = 8'd51; s_vel = 7'd90;
    idle(1);
    s_vld = 1'b0;
    idle(2);
    s_vld = 1'b1; s_st = 4'h8; s_nt = 8'd51; s_vel = 7'd0;
    idle(1);
    s_vld = 1'b0;
    chk("s_short_dur", 64'(s_durs[0]), 64'd3);
    chk("s_shift_dur", 64'(s_durs[1]), 64'd15);
    chk("s_shift_note", 64'(s_notes[1]), 64'd50);
    chk("s_ovf", 64'(s_ovf), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_duration_tracker.md
Name: note_duration_tracker

Overview:
Sits directly upstream of the staff renderer. Consumes decoded MIDI note-on/note-off messages and times each held note in clk_camera_in cycles using up to 5 concurrent voice slots. On release, it pushes the completed {note, duration} pair into a 5-deep history. That history drives the renderer's notes_in/durations_in arrays directly.

Parameters:
NUM_VOICES, 5, number of concurrent held-note slots; also the history depth.
NOTE_WIDTH, 8, note number width; MIDI uses 7 bits, MSB always 0.
DUR_WIDTH, 30, duration counter width in cycles.

Ports:
clk_camera_in  input  1  system clock; all logic on its rising edge
rst_in  input  1  synchronous, active-high reset
midi_valid_in  input  1  one-cycle strobe: message fields valid this cycle
midi_status_in  input  4  status upper nibble: 4'h9 = note-on, 4'h8 = note-off; other values ignored
midi_note_in  input  NOTE_WIDTH  note number
midi_velocity_in  input  7  velocity; note-on with velocity 0 is treated as note-off
notes_out  output  [NOTE_WIDTH-1:0] x NUM_VOICES  completed notes; index 0 = newest
durations_out  output  [DUR_WIDTH-1:0] x NUM_VOICES  durations matching notes_out indices
active_mask_out  output  NUM_VOICES  bit i = voice slot i currently held
notes_valid_out  output  1  one-cycle pulse: history shifted this cycle
overflow_out  output  1  one-cycle pulse: note-on dropped because all slots are busy

Behaviour:
- Interface: one clock, clk_camera_in. rst_in is synchronous and active-high.
- Reset: all outputs 0. All slots inactive with counters 0. History notes and durations all 0.
- Reset mid-operation: held notes are discarded with no history entry. Reset has priority over a same-cycle message.
- Voice slot state: active bit, note, DUR_WIDTH-bit counter.
- Counter while active: +1 per cycle, saturating at 2^DUR_WIDTH-1 (no wrap).
- Message classification, sampled when midi_valid_in = 1:
  - NOTE_ON: status 4'h9 and velocity != 0.
  - NOTE_OFF: status 4'h8, or status 4'h9 with velocity 0.
  - Anything else: ignored.
- NOTE_ON, note already active in a slot (retrigger): that slot's counter is set to 0; no history push.
- NOTE_ON, otherwise: the lowest-index inactive slot is allocated (active=1, note latched, counter=0).
- NOTE_ON, no inactive slot: message dropped; overflow_out pulses for exactly 1 cycle; state unchanged.
- NOTE_OFF, note matches an active slot:
  - History shifts: entry i moves to i+1, entry NUM_VOICES-1 is discarded.
  - Entry 0 = {slot note, slot counter}.
  - Slot cleared (active=0, counter=0).
  - notes_valid_out pulses for exactly 1 cycle.
- NOTE_OFF, no match: ignored; no pulse.
- Duration definition: with note-on accepted at edge N and note-off accepted at edge M, duration = M-N (unsaturated case).
- Latency: all outputs are registered and updated on the edge that samples the message. notes_valid_out is high during the cycle after that edge, aligned with the new history.
- Held slots are never visible in the history; active_mask_out shows them.
- At most one message per cycle by construction. No backpressure: the upstream source never stalls.
- Duplicate notes in slots are impossible because of the retrigger rule.

Decomposition:
- Shared package midi_pkg:
  - MIDI_NOTE_ON = 4'h9, MIDI_NOTE_OFF = 4'h8.
  - NUM_VOICES, NOTE_WIDTH, DUR_WIDTH defaults.
  - voice_slot_t packed struct {active, note, count}.
  - history_entry_t {note, duration}.
  The staff renderer imports the same widths from this package.
- One sub-module, voice_slot:
  - Holds one slot with its saturating counter.
  - Inputs: alloc, release, retrigger, note_in.
  - Outputs: match (active and note equal) and slot state.
  - Instantiated NUM_VOICES times.
- Top level: priority-encodes the free slot, one-hot selects the match, owns the history shift register.

Test Plan:
- Reset, then note-on 60 at cycle 10 and note-off 60 at cycle 25 -> notes_out[0]=60, durations_out[0]=15, notes_valid_out high 1 cycle, active_mask_out back to 0.
- Six note-ons (60..65) with no note-offs -> active_mask_out=5'b11111; note 65 raises overflow_out for 1 cycle; release of 65 is ignored (no notes_valid_out).
- Release 60, then 61, then 62 -> notes_out[0..2] = 62, 61, 60; a 6th completed note pushes the first out of index 4.
- Note-on 64 at cycle 0, re-note-on 64 at cycle 8, note-off at cycle 20 -> single history entry, note 64, duration 12.
- Note-on 67 velocity 0 while 67 is held -> treated as release; note-off 70 never pressed -> no change; status 4'hB -> ignored.
- Assert rst_in while 3 notes are held, during a same-cycle note-off -> all outputs 0 the next cycle, no history entry. Force a counter to 2^30-2 and hold 5 cycles -> duration 2^30-1 (saturated).
